// File: rtl/physics_tick_scheduler.sv
// Physics tick generator and two-player update-unit sequencer with watchdog and overrun count.
// Optional feature: define SCHED_ROUND_ROBIN_EN to alternate which player is updated first.
module physics_tick_scheduler #(
  parameter int unsigned SRC_FREQ  = 65_000_000,
  parameter int unsigned TICK_FREQ = 100,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pause_i,
  input  logic [1:0] player_en_i,
  input  logic       upd_done_i,
  output logic       tick_o,
  output logic       upd_start_o,
  output logic       upd_sel_o,
  output logic       frame_done_o,
  output logic       busy_o,
  output logic       timeout_err_o,
  output logic [7:0] overrun_cnt_o
);

  localparam int unsigned DIV  = SRC_FREQ / TICK_FREQ;
  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DivW-1:0] DivMax  = DivW'(DIV - 1);
  localparam logic [7:0]      WdogMax = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e          state_q;
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            tick_q, tick_d;
  logic [1:0]      pending_q;
  logic            sel_q;
  logic [7:0]      wdog_q;
  logic            timeout_err_q;
  logic [7:0]      overrun_q;
  logic            first;
  logic            other;

  // Tick divider
  always_comb begin
    div_cnt_d = div_cnt_q;
    tick_d    = 1'b0;
    if (!pause_i) begin
      if (div_cnt_q == DivMax) begin
        div_cnt_d = '0;
        tick_d    = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + DivW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
    end
  end

`ifdef SCHED_ROUND_ROBIN_EN
  logic first_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      first_q <= 1'b0;
    end else if (state_q == StDone) begin
      first_q <= ~first_q;
    end
  end

  assign first = first_q;
`else
  assign first = 1'b0;
`endif

  assign other = ~sel_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      pending_q     <= 2'b00;
      sel_q         <= 1'b0;
      wdog_q        <= 8'd0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 8'd0;
    end else begin
      // Ticks that land while a frame is still in flight are dropped, never queued.
      if (tick_q && (state_q != StIdle) && (overrun_q != 8'hff)) begin
        overrun_q <= overrun_q + 8'd1;
      end
      unique case (state_q)
        StIdle: begin
          if (tick_q) begin
            pending_q <= player_en_i;
            if (player_en_i == 2'b00) begin
              // Empty frame passes through WAIT so frame_done lands two cycles after tick.
              state_q <= StWait;
            end else begin
              sel_q   <= player_en_i[first] ? first : ~first;
              state_q <= StIssue;
            end
          end
        end
        StIssue: begin
          wdog_q  <= 8'd0;
          state_q <= StWait;
        end
        StWait: begin
          if (pending_q == 2'b00) begin
            state_q <= StDone;
          end else if (upd_done_i || (wdog_q == WdogMax)) begin
            if (!upd_done_i) begin
              timeout_err_q <= 1'b1;
            end
            pending_q[sel_q] <= 1'b0;
            if (pending_q[other]) begin
              sel_q   <= other;
              state_q <= StIssue;
            end else begin
              state_q <= StDone;
            end
          end else begin
            wdog_q <= wdog_q + 8'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign tick_o        = tick_q;
  assign upd_start_o   = (state_q == StIssue);
  assign upd_sel_o     = sel_q;
  assign frame_done_o  = (state_q == StDone);
  assign busy_o        = (state_q != StIdle);
  assign timeout_err_o = timeout_err_q;
  assign overrun_cnt_o = overrun_q;

endmodule

// File: tb/tb_physics_tick_scheduler.sv
// Directed self-checking bench for physics_tick_scheduler (DIV=10, TIMEOUT=4).
module tb_physics_tick_scheduler;

`ifdef SCHED_ROUND_ROBIN_EN
  localparam bit Rr = 1'b1;
`else
  localparam bit Rr = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pause;
  logic [1:0] player_en;
  logic       upd_done;
  logic       tick;
  logic       upd_start;
  logic       upd_sel;
  logic       frame_done;
  logic       busy;
  logic       timeout_err;
  logic [7:0] overrun_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  physics_tick_scheduler #(
    .SRC_FREQ (1000),
    .TICK_FREQ(100),
    .TIMEOUT  (4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .pause_i      (pause),
    .player_en_i  (player_en),
    .upd_done_i   (upd_done),
    .tick_o       (tick),
    .upd_start_o  (upd_start),
    .upd_sel_o    (upd_sel),
    .frame_done_o (frame_done),
    .busy_o       (busy),
    .timeout_err_o(timeout_err),
    .overrun_cnt_o(overrun_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < 40);
    if (!tick) check("tick_seen", 32'd0, 32'd1);
  endtask

  // Offsets are cycles after the tick; 0 means no start expected in that slot.
  task automatic frame_check(input string tag, input int a, input logic sa, input int b,
                             input logic sb, input int d, input logic [1:0] mid_en);
    for (int k = 1; k <= d + 1; k++) begin
      step();
      if (k == 1) begin
        player_en = mid_en;
        check({tag, "_busy"}, 32'(busy), 32'd1);
      end
      check({tag, "_start"}, 32'(upd_start), 32'((k == a) || (k == b)));
      if (k == a) check({tag, "_sel_a"}, 32'(upd_sel), 32'(sa));
      if (k == b) check({tag, "_sel_b"}, 32'(upd_sel), 32'(sb));
      check({tag, "_fdone"}, 32'(frame_done), 32'(k == d));
      if (k == d + 1) check({tag, "_idle"}, 32'(busy), 32'd0);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({tick, upd_start, upd_sel, frame_done, busy, timeout_err, overrun_cnt});
  endfunction

  initial begin
    int n;
    logic seen;
    rst_n     = 1'b0;
    pause     = 1'b0;
    player_en = 2'b00;
    upd_done  = 1'b0;

    for (int i = 0; i < 3; i++) step();
    check("rst_outs", all_outs(), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      check("pre_tick", all_outs(), 32'd0);
    end
    step();
    check("first_tick", 32'(tick), 32'd1);

    // Empty mask right after reset, then full frames with update done held high
    frame_check("empty0", 0, 1'b0, 0, 1'b0, 2, 2'b11);
    player_en = 2'b11;
    upd_done  = 1'b1;
    wait_tick();
    frame_check("both_a", 1, Rr, 3, ~Rr, 5, 2'b00);
    player_en = 2'b11;
    wait_tick();
    frame_check("both_b", 1, 1'b0, 3, 1'b1, 5, 2'b11);
    player_en = 2'b10;
    wait_tick();
    frame_check("single", 1, 1'b1, 0, 1'b0, 3, 2'b11);
    player_en = 2'b00;
    wait_tick();
    frame_check("empty1", 0, 1'b0, 0, 1'b0, 2, 2'b11);

    // Hung update unit: both players time out, tick at T+10 is dropped
    player_en = 2'b11;
    upd_done  = 1'b0;
    check("terr_pre", 32'(timeout_err), 32'd0);
    wait_tick();
    frame_check("tmo", 1, Rr, 7, ~Rr, 13, 2'b11);
    check("tmo_err", 32'(timeout_err), 32'd1);
    check("ovr_one", 32'(overrun_cnt), 32'd1);

    for (int i = 0; i < 6000; i++) step();
    check("ovr_sat", 32'(overrun_cnt), 32'd255);
    check("terr_sticky", 32'(timeout_err), 32'd1);

    // Pause mid-count at div_cnt=3; resume needs 7 more cycles
    upd_done  = 1'b1;
    player_en = 2'b00;
    wait_tick();
    wait_tick();
    for (int i = 0; i < 3; i++) step();
    pause = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      seen = seen | tick;
    end
    check("pause_no_tick", 32'(seen), 32'd0);
    pause = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < 30);
    check("pause_resume", 32'(n), 32'd7);

    // Reset during WAIT aborts the frame
    player_en = 2'b11;
    upd_done  = 1'b0;
    wait_tick();
    step();
    step();
    check("wait_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step();
    check("rst_abort", all_outs(), 32'd0);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      seen = seen | upd_start | frame_done | tick;
    end
    check("rst_quiet", 32'(seen), 32'd0);
    step();
    check("rst_tick", 32'(tick), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
